// File: rtl/corelet_seq.sv
// Job sequencer for one corelet: walks kernel load, activation load, execute and
// drain phases, issuing one handshaked operation per cycle into the instruction word.
module corelet_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int CNT_BW  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CNT_BW-1:0] num_vec,
  input  logic [CNT_BW-1:0] num_kij,
  input  logic              l0_full,
  input  logic              l0_ready,
  input  logic              ififo_full,
  input  logic              ififo_empty,
  input  logic              ofifo_valid,
  output logic [34:0]       inst,
  output logic              busy,
  output logic              done,
  output logic [CNT_BW-1:0] kij_idx
);

  typedef enum logic [3:0] {
    IDLE, KLOAD, KPUSH, KWAIT, ALOAD, EXEC, DRAIN, NEXT, FIN
  } state_t;

  localparam logic [CNT_BW-1:0] COL_LAST  = CNT_BW'(col - 1);
  localparam logic [CNT_BW-1:0] WAIT_LAST = CNT_BW'(row + col - 1);

  // bw/psum_bw size the MAC datapath; an empty block marks a psum narrower than a product.
  if (psum_bw < 2 * bw) begin : g_psum_narrow
  end

  state_t            state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [CNT_BW-1:0] nvec_q, nvec_d;
  logic [CNT_BW-1:0] nkij_q, nkij_d;
  logic [CNT_BW-1:0] kij_q, kij_d;
  logic              mode_q, mode_d;

  logic [6:0]        op;
  logic              acc;
  logic              issue;
  logic              aborting;
  logic [CNT_BW-1:0] vec_last;
  logic [CNT_BW-1:0] drain_last;
  logic [CNT_BW-1:0] kij_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nvec_q  <= '0;
      nkij_q  <= '0;
      kij_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
      nkij_q  <= nkij_d;
      kij_q   <= kij_d;
      mode_q  <= mode_d;
    end
  end

  assign aborting   = abort && (state_q != IDLE);
  assign vec_last   = nvec_q - 1'b1;
  assign drain_last = mode_q ? COL_LAST : vec_last;
  assign kij_inc    = kij_q + 1'b1;

  always_comb begin
    state_d = state_q;
    nvec_d  = nvec_q;
    nkij_d  = nkij_q;
    kij_d   = kij_q;
    mode_d  = mode_q;
    op      = '0;
    acc     = 1'b0;
    issue   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          nvec_d = num_vec;
          nkij_d = num_kij;
          kij_d  = '0;
          if (num_vec == '0 || (!mode && num_kij == '0)) state_d = FIN;
          else state_d = mode ? ALOAD : KLOAD;
        end
      end
      KLOAD: begin
        issue = !l0_full;
        op[2] = issue;
        if (issue && cnt_q == COL_LAST) state_d = KPUSH;
      end
      KPUSH: begin
        issue = l0_ready;
        op[3] = issue;
        op[0] = issue;
        if (issue && cnt_q == COL_LAST) state_d = KWAIT;
      end
      KWAIT: begin
        issue = 1'b1;
        if (cnt_q == WAIT_LAST) state_d = ALOAD;
      end
      ALOAD: begin
        // OS writes land in L0 and ififo together, so both must have room
        issue = !l0_full && (!mode_q || !ififo_full);
        op[2] = issue;
        op[4] = issue && mode_q;
        if (issue && cnt_q == vec_last) state_d = EXEC;
      end
      EXEC: begin
        issue = l0_ready && (!mode_q || !ififo_empty);
        op[3] = issue;
        op[1] = issue;
        op[5] = issue && mode_q;
        if (issue && cnt_q == vec_last) state_d = DRAIN;
      end
      DRAIN: begin
        issue = ofifo_valid;
        op[6] = issue;
        acc   = issue && !mode_q;
        if (issue && cnt_q == drain_last) state_d = NEXT;
      end
      NEXT: begin
        kij_d = kij_inc;
        if (!mode_q && kij_inc < nkij_q) state_d = KLOAD;
        else state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (aborting) begin
      state_d = IDLE;
      kij_d   = '0;
      op      = '0;
      acc     = 1'b0;
      issue   = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (issue)         cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN) && !aborting;
  assign kij_idx = kij_q;
  assign inst    = {busy & mode_q, acc, 26'b0, op};

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: directed jobs push hand-computed instruction
// events; a negedge monitor pops and compares whenever an op or done is presented.
module tb_corelet_seq;

  localparam int CNT_BW = 11;
  localparam logic [34:0] MB  = 35'h4_0000_0000; // inst[34] mode
  localparam logic [34:0] ACC = 35'h2_0000_0000; // inst[33] sfp acc

  logic              clk, reset, start, abort, mode;
  logic [CNT_BW-1:0] num_vec, num_kij;
  logic              l0_full, l0_ready, ififo_full, ififo_empty, ofifo_valid;
  logic [34:0]       inst;
  logic              busy, done;
  logic [CNT_BW-1:0] kij_idx;

  typedef struct {
    logic [34:0]       inst;
    logic              done;
    logic [CNT_BW-1:0] kij;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   len;

  corelet_seq #(.row(8), .col(8), .bw(4), .psum_bw(16), .CNT_BW(CNT_BW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .num_vec(num_vec), .num_kij(num_kij), .l0_full(l0_full), .l0_ready(l0_ready),
    .ififo_full(ififo_full), .ififo_empty(ififo_empty), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_n(input logic [34:0] i, input logic d, input logic [CNT_BW-1:0] k, input int n);
    exp_t e;
    e.inst = i; e.done = d; e.kij = k;
    for (int j = 0; j < n; j++) exp_q.push_back(e);
  endtask

  task automatic exp_ws_pass(input int nv, input logic [CNT_BW-1:0] k);
    push_n(35'h04, 1'b0, k, 8);          // kernel write into L0
    push_n(35'h09, 1'b0, k, 8);          // L0 read + kernel load
    push_n(35'h04, 1'b0, k, nv);         // activation write
    push_n(35'h0A, 1'b0, k, nv);         // L0 read + execute
    push_n(ACC | 35'h40, 1'b0, k, nv);   // ofifo read + accumulate
  endtask

  task automatic exp_os(input int nv);
    push_n(MB | 35'h14, 1'b0, '0, nv);
    push_n(MB | 35'h2A, 1'b0, '0, nv);
    push_n(MB | 35'h40, 1'b0, '0, 8);
  endtask

  task automatic start_job(input logic m, input int nv, input int nk);
    mode    = m;
    num_vec = CNT_BW'(nv);
    num_kij = CNT_BW'(nk);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    chk("busy after start", 64'(busy), 64'd1);
  endtask

  // Index 0 is the first cycle after the start edge; returns the index where done is seen.
  task automatic run_job(input string name, input int stall_lo, input int stall_hi,
                         input int inj_at, input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      l0_full = (i >= stall_lo) && (i < stall_hi);
      start   = (i == inj_at);
      if (i == inj_at) begin
        mode    = ~mode;
        num_vec = 11'd9;
      end
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    l0_full = 1'b0;
    @(posedge clk); #1;
    chk({name, " busy after done"}, 64'(busy), 64'd0);
    chk({name, " done one cycle"}, 64'(done), 64'd0);
    chk({name, " events left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (inst[2] && inst[3]) begin
        bad++;
        $display("FAIL exclusive wr/rd: inst=%h, required bits 2 and 3 not both set", inst);
      end
      if (inst[6:0] != 7'd0 || done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected event: inst=%h done=%b kij=%0d, required none", inst, done, kij_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (inst !== e.inst || done !== e.done || kij_idx !== e.kij) begin
            bad++;
            $display("FAIL event: inst=%h done=%b kij=%0d, required inst=%h done=%b kij=%0d",
                     inst, done, kij_idx, e.inst, e.done, e.kij);
          end else begin
            $display("event ok: inst=%h done=%b kij=%0d", inst, done, kij_idx);
          end
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    num_vec = '0; num_kij = '0;
    l0_full = 1'b0; l0_ready = 1'b1; ififo_full = 1'b0; ififo_empty = 1'b0; ofifo_valid = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset inst", 64'(inst), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset kij", 64'(kij_idx), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // WS, two kernel passes: per pass 8+8+16+16+16+16+1 cycles
    exp_ws_pass(16, 11'd0);
    exp_ws_pass(16, 11'd1);
    push_n(35'h0, 1'b1, 11'd2, 1);
    start_job(1'b0, 16, 2);
    run_job("ws", -1, -1, -1, 400, len);
    chk("ws length", 64'(len), 64'd162);

    // OS, with a start/mode/num_vec change mid-job that must be ignored
    exp_os(4);
    push_n(MB, 1'b1, 11'd1, 1);
    start_job(1'b1, 4, 0);
    run_job("os", -1, -1, 3, 100, len);
    chk("os length", 64'(len), 64'd17);

    // OS with l0_full held 5 cycles after the first activation write
    exp_os(4);
    push_n(MB, 1'b1, 11'd1, 1);
    start_job(1'b1, 4, 0);
    run_job("stall", 1, 6, -1, 100, len);
    chk("stall length", 64'(len), 64'd22);

    // Empty jobs go straight to FIN
    push_n(35'h0, 1'b1, 11'd0, 1);
    start_job(1'b0, 0, 2);
    run_job("nv0 ws", -1, -1, -1, 20, len);
    chk("nv0 ws length", 64'(len), 64'd0);
    push_n(35'h0, 1'b1, 11'd0, 1);
    start_job(1'b0, 5, 0);
    run_job("nk0 ws", -1, -1, -1, 20, len);
    chk("nk0 ws length", 64'(len), 64'd0);
    push_n(MB, 1'b1, 11'd0, 1);
    start_job(1'b1, 0, 0);
    run_job("nv0 os", -1, -1, -1, 20, len);
    chk("nv0 os length", 64'(len), 64'd0);

    // Abort in EXEC at cnt=3 (OS, num_vec=8: EXEC starts at index 8)
    push_n(MB | 35'h14, 1'b0, '0, 8);
    push_n(MB | 35'h2A, 1'b0, '0, 3);
    start_job(1'b1, 8, 0);
    repeat (11) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort inst", 64'(inst), 64'd0);
    chk("abort kij", 64'(kij_idx), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort events left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_os(4);
    push_n(MB, 1'b1, 11'd1, 1);
    start_job(1'b1, 4, 0);
    run_job("post-abort", -1, -1, -1, 100, len);
    chk("post-abort length", 64'(len), 64'd17);

    // Reset mid-DRAIN (WS, num_vec=4, one pass: DRAIN starts at index 40)
    push_n(35'h04, 1'b0, '0, 8);
    push_n(35'h09, 1'b0, '0, 8);
    push_n(35'h04, 1'b0, '0, 4);
    push_n(35'h0A, 1'b0, '0, 4);
    push_n(ACC | 35'h40, 1'b0, '0, 2);
    start_job(1'b0, 4, 1);
    repeat (42) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    chk("async reset inst", 64'(inst), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    chk("async reset kij", 64'(kij_idx), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no resume busy", 64'(busy), 64'd0);
    chk("reset events left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Maximum num_vec must not wrap
    exp_os(2047);
    push_n(MB, 1'b1, 11'd1, 1);
    start_job(1'b1, 2047, 0);
    run_job("max nv", -1, -1, -1, 5000, len);
    chk("max nv length", 64'(len), 64'd4103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
